// File: rtl/display_pkg.sv
// Shared constants and state type for the binary-to-BCD display path.
// Sized for an 8-digit packed BCD display fed from a 27-bit binary window.
package display_pkg;
   localparam int NUM_DIGITS = 8;
   localparam int SHIFT_BITS = 27;
   localparam int CNT_W      = 5;

   localparam logic [31:0] MAX_DISPLAY_VAL = 32'd99_999_999;
   localparam logic [31:0] BCD_SATURATED   = 32'h9999_9999;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_CONVERT = 1'b1
   } state_t;
endpackage

// File: rtl/bin_to_bcd_display_if.sv
// Request/result bundle between a value producer and the BCD converter.
// The master supplies values; the slave (converter) returns digits and status.
interface bin_to_bcd_display_if;
   logic [31:0] bin_in;
   logic        valid_in;
   logic        ready_out;
   logic [31:0] bcd_out;
   logic        done_out;
   logic        overflow_out;

   modport master (
      output bin_in, valid_in,
      input  ready_out, bcd_out, done_out, overflow_out
   );

   modport slave (
      input  bin_in, valid_in,
      output ready_out, bcd_out, done_out, overflow_out
   );
endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: digits of 5 or more get +3
// so the following left shift carries correctly into the next decade.
module bcd_digit_adjust (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   // Add-3 correction ahead of the shift.
   always_comb begin
      digit_o = digit_i;
      if (digit_i >= 4'd5) begin
         digit_o = digit_i + 4'd3;
      end else begin
         digit_o = digit_i;
      end
   end

endmodule

// File: rtl/bin_to_bcd_display.sv
// Sequential shift-and-add-3 converter: 32-bit binary in, 8 packed BCD digits out,
// one bit per clock, with saturation to all nines for values above 99,999,999.
module bin_to_bcd_display
   import display_pkg::*;
(
   input  logic               clk_in,
   input  logic               rst_in,
   bin_to_bcd_display_if.slave bus
);

   state_t                  state_q;
   logic [SHIFT_BITS-1:0]   shift_q;
   logic [31:0]             scratch_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [31:0]             bcd_q;
   logic                    done_q;
   logic                    ovf_q;

   logic [31:0]             adj_s;
   logic [31:0]             scratch_d;

   genvar g;
   generate
      for (g = 0; g < NUM_DIGITS; g++) begin : g_adj
         bcd_digit_adjust u_adj (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (adj_s[4*g +: 4])
         );
      end
   endgenerate

   // The top digit never exceeds 9 for in-range values, so its carry-out is discarded.
   assign scratch_d = (adj_s << 1) | {31'd0, shift_q[SHIFT_BITS-1]};

   // Control FSM with the conversion datapath and registered outputs.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         scratch_q <= 32'd0;
         cnt_q     <= '0;
         bcd_q     <= 32'd0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.valid_in) begin
                  if (bus.bin_in > MAX_DISPLAY_VAL) begin
                     bcd_q  <= BCD_SATURATED;
                     ovf_q  <= 1'b1;
                     done_q <= 1'b1;
                  end else begin
                     shift_q   <= bus.bin_in[SHIFT_BITS-1:0];
                     scratch_q <= 32'd0;
                     cnt_q     <= CNT_W'(SHIFT_BITS - 1);
                     state_q   <= ST_CONVERT;
                  end
               end
            end
            ST_CONVERT: begin
               scratch_q <= scratch_d;
               shift_q   <= shift_q << 1;
               if (cnt_q == '0) begin
                  bcd_q   <= scratch_d;
                  ovf_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ready_out    = (state_q == ST_IDLE);
   assign bus.bcd_out      = bcd_q;
   assign bus.done_out     = done_q;
   assign bus.overflow_out = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Self-checking bench for bin_to_bcd_display: directed cases plus randomized
// values compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_display;

   logic clk_in;
   logic rst_in;
   int   checks;
   int   failures;

   logic [31:0] model_bcd;
   logic        model_ovf;

   bin_to_bcd_display_if ifc ();

   bin_to_bcd_display dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (ifc)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] ref_bcd(input logic [31:0] v);
      logic [31:0] r;
      longint      x;
      if (v > 32'd99_999_999) return 32'h9999_9999;
      x = longint'(v);
      r = 32'd0;
      for (int k = 0; k < 8; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic digits_ok(input logic [31:0] v);
      for (int k = 0; k < 8; k++) begin
         if (v[4*k +: 4] > 4'd9) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at the negedge after the accept edge of an in-range value.
   task automatic wait_result(input logic [31:0] v);
      logic [31:0] exp;
      exp = ref_bcd(v);
      for (int i = 0; i < 27; i++) begin
         chk("mid_done", {31'd0, ifc.done_out}, 32'd0);
         chk("mid_ready", {31'd0, ifc.ready_out}, 32'd0);
         chk("mid_bcd_held", ifc.bcd_out, model_bcd);
         chk("mid_ovf_held", {31'd0, ifc.overflow_out}, {31'd0, model_ovf});
         @(negedge clk_in);
      end
      model_bcd = exp;
      model_ovf = 1'b0;
      chk("final_done", {31'd0, ifc.done_out}, 32'd1);
      chk("final_bcd", ifc.bcd_out, exp);
      chk("final_ovf", {31'd0, ifc.overflow_out}, 32'd0);
      chk("final_ready", {31'd0, ifc.ready_out}, 32'd1);
      chk("final_digits", {31'd0, digits_ok(ifc.bcd_out)}, 32'd1);
   endtask

   task automatic convert(input logic [31:0] v);
      int n;
      n = 0;
      while (!ifc.ready_out && n < 64) begin
         @(negedge clk_in);
         n++;
      end
      chk("ready_before_accept", {31'd0, ifc.ready_out}, 32'd1);
      ifc.valid_in = 1'b1;
      ifc.bin_in   = v;
      @(negedge clk_in);
      ifc.valid_in = 1'b0;
      ifc.bin_in   = $urandom;
      if (v > 32'd99_999_999) begin
         model_bcd = 32'h9999_9999;
         model_ovf = 1'b1;
         chk("sat_done", {31'd0, ifc.done_out}, 32'd1);
         chk("sat_bcd", ifc.bcd_out, model_bcd);
         chk("sat_ovf", {31'd0, ifc.overflow_out}, 32'd1);
         chk("sat_ready", {31'd0, ifc.ready_out}, 32'd1);
      end else begin
         wait_result(v);
      end
      @(negedge clk_in);
      chk("done_cleared", {31'd0, ifc.done_out}, 32'd0);
      chk("ready_after", {31'd0, ifc.ready_out}, 32'd1);
   endtask

   initial begin
      logic [31:0] v;
      checks       = 0;
      failures     = 0;
      model_bcd    = 32'd0;
      model_ovf    = 1'b0;
      rst_in       = 1'b0;
      ifc.valid_in = 1'b0;
      ifc.bin_in   = 32'd0;
      repeat (3) @(negedge clk_in);
      chk("rst_bcd", ifc.bcd_out, 32'd0);
      chk("rst_done", {31'd0, ifc.done_out}, 32'd0);
      chk("rst_ovf", {31'd0, ifc.overflow_out}, 32'd0);
      rst_in = 1'b1;
      @(negedge clk_in);
      chk("rst_ready", {31'd0, ifc.ready_out}, 32'd1);

      convert(32'd0);
      convert(32'd12_345_678);
      convert(32'd99_999_999);
      convert(32'd100_000_000);
      convert(32'hFFFF_FFFF);
      convert(32'd134_217_727);

      // Held request during conversion is ignored, then taken on the first idle edge.
      ifc.valid_in = 1'b1;
      ifc.bin_in   = 32'd42;
      @(negedge clk_in);
      ifc.bin_in   = 32'd7;
      wait_result(32'd42);
      @(negedge clk_in);
      ifc.valid_in = 1'b0;
      wait_result(32'd7);
      @(negedge clk_in);

      // Reset in the middle of a conversion discards the partial result.
      ifc.valid_in = 1'b1;
      ifc.bin_in   = 32'd87_654_321;
      @(posedge clk_in);
      #1 ifc.valid_in = 1'b0;
      repeat (10) @(posedge clk_in);
      #2 rst_in = 1'b0;
      #1;
      chk("async_rst_bcd", ifc.bcd_out, 32'd0);
      chk("async_rst_done", {31'd0, ifc.done_out}, 32'd0);
      chk("async_rst_ovf", {31'd0, ifc.overflow_out}, 32'd0);
      chk("async_rst_ready", {31'd0, ifc.ready_out}, 32'd1);
      @(negedge clk_in);
      rst_in    = 1'b1;
      model_bcd = 32'd0;
      model_ovf = 1'b0;
      @(negedge clk_in);
      convert(32'd5);

      for (int i = 0; i < 1000; i++) begin
         if (i % 2 == 0) v = $urandom_range(99_999_999, 0);
         else            v = $urandom;
         convert(v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
